// File: rtl/pfifo_sync.sv
// Single-clock packet FIFO: words are written speculatively, then committed or
// dropped as a packet; the reader only ever sees committed packets.
module pfifo_sync #(
    parameter int W      = 8,
    parameter int ORDER  = 4,
    parameter int PORDER = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [W-1:0]      in,
    input  logic              put,
    input  logic              commit,
    input  logic              drop,
    output logic              full,
    output logic [W-1:0]      out,
    output logic              out_valid,
    output logic              out_last,
    input  logic              get,
    output logic              empty,
    output logic [ORDER:0]    used,
    output logic [PORDER:0]   packets,
    output logic              overrun
);

    localparam int DEPTH  = 2 ** ORDER;
    localparam int PDEPTH = 2 ** PORDER;

    typedef logic [ORDER:0]  ptr_t;
    typedef logic [PORDER:0] pptr_t;

    logic [W-1:0] ram_q [DEPTH];
    ptr_t         pq_q  [PDEPTH];

    ptr_t         wptr_q, wptr_d, rptr_q, rptr_d, head_q, head_d;
    pptr_t        pqw_q, pqw_d, pqr_q, pqr_d;
    logic [W-1:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;
    logic         overrun_q, overrun_d;

    logic         word_full_s, pq_full_s, full_s, empty_s;
    logic         do_put_s, do_get_s, do_commit_s, last_s;
    ptr_t         wptr_put_s, tail_s;

    // Status flags come only from registered pointers, so a pop frees space a cycle later.
    assign used        = wptr_q - rptr_q;
    assign packets     = pqw_q - pqr_q;
    assign word_full_s = (used == ptr_t'(DEPTH));
    assign pq_full_s   = (packets == pptr_t'(PDEPTH));
    assign full_s      = word_full_s | pq_full_s;
    assign empty_s     = (rptr_q == head_q);
    assign tail_s      = pq_q[pqr_q[PORDER-1:0]];

    assign full      = full_s;
    assign empty     = empty_s;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overrun   = overrun_q;

    // Next-state logic for write, commit/drop, read and status registers.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        head_d      = head_q;
        pqw_d       = pqw_q;
        pqr_d       = pqr_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        overrun_d   = overrun_q;
        do_commit_s = 1'b0;

        do_put_s   = put & ~full_s;
        do_get_s   = get & ~empty_s;
        wptr_put_s = wptr_q + (do_put_s ? ptr_t'(1) : ptr_t'(0));
        last_s     = ((rptr_q + ptr_t'(1)) == tail_s);

        if (put & full_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        // Drop beats commit; a commit of an empty packet or into a full queue is ignored.
        if (drop) begin
            wptr_d = head_q;
        end else if (commit && !pq_full_s && (wptr_put_s != head_q)) begin
            do_commit_s = 1'b1;
            wptr_d      = wptr_put_s;
            head_d      = wptr_put_s;
            pqw_d       = pqw_q + pptr_t'(1);
        end else begin
            wptr_d = wptr_put_s;
        end

        if (do_get_s) begin
            out_d       = ram_q[rptr_q[ORDER-1:0]];
            out_valid_d = 1'b1;
            out_last_d  = last_s;
            rptr_d      = rptr_q + ptr_t'(1);
            if (last_s) begin
                pqr_d = pqr_q + pptr_t'(1);
            end else begin
                pqr_d = pqr_q;
            end
        end else begin
            out_d = out_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            head_q      <= '0;
            pqw_q       <= '0;
            pqr_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            head_q      <= head_d;
            pqw_q       <= pqw_d;
            pqr_q       <= pqr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage arrays need no reset: pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_put_s && !reset) begin
            ram_q[wptr_q[ORDER-1:0]] <= in;
        end
        if (do_commit_s && !reset) begin
            pq_q[pqw_q[PORDER-1:0]] <= wptr_put_s;
        end
    end

endmodule
